mem_req_ctrl: RTL and testbench

- Initiator side of the single-port synchronous memory (A/W/D/Q port, one-cycle registered read, Q not updated on write cycles).
- Accepts load/store requests from the processor over valid/ready and drives the memory's A/W/D.
- Captures Q and returns read data over a valid/ready response channel.
- Memory has no byte enables, so partial-word stores are done as read-modify-write.

---
 rtl/mem_req_pkg.sv | 20 ++
 rtl/mem_req_ctrl_if.sv | 38 +++
 rtl/mem_be_merge.sv | 17 +
 rtl/mem_req_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_req_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the memory request controller and its byte-merge helper.
package mem_req_pkg;

  localparam int DEF_WORD = 32;
  localparam int DEF_ADDR = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // Byte-enable width follows the data width; never set independently.
  function automatic int be_width(input int word);
    return word / 8;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Processor request/response channel plus the A/W/D/Q memory port, bundled for the controller.
interface mem_req_ctrl_if
  import mem_req_pkg::*;
#(
  parameter int WORD = DEF_WORD,
  parameter int ADDR = DEF_ADDR
);
  localparam int BE = be_width(WORD);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [ADDR-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic [BE-1:0]   req_be;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [WORD-1:0] rsp_rdata;

  logic [ADDR-1:0] mem_A;
  logic            mem_W;
  logic [WORD-1:0] mem_D;
  logic [WORD-1:0] mem_Q;

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_Q,
    output req_ready, rsp_valid, rsp_rdata, mem_A, mem_W, mem_D
  );

  // Processor + memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_Q,
    input  req_ready, rsp_valid, rsp_rdata, mem_A, mem_W, mem_D
  );

endinterface

// File: rtl/mem_be_merge.sv
// Byte-wise merge of store data over an old word, used for read-modify-write stores.
module mem_be_merge
  import mem_req_pkg::*;
#(
  parameter int WORD = DEF_WORD
) (
  input  logic [WORD-1:0]           old_i,
  input  logic [WORD-1:0]           new_i,
  input  logic [be_width(WORD)-1:0] be_i,
  output logic [WORD-1:0]           merged_o
);

  for (genvar i = 0; i < be_width(WORD); i++) begin : g_byte
    assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store initiator for a single-port synchronous memory; partial stores become read-modify-write.
// Optional: define MEM_REQ_WRITE_ACK_EN to return a zero-data response for every store.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int WORD = DEF_WORD,
  parameter int ADDR = DEF_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  mem_req_ctrl_if.slave  bus
);
  localparam int BE = be_width(WORD);

  state_e          state_q;
  logic [ADDR-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [BE-1:0]   be_q;
  logic            we_q;
  logic            rsp_valid_q;
  logic [WORD-1:0] rsp_rdata_q;

  logic            full_be;
  logic            wr_full;
  logic            wr_merge;
  logic [WORD-1:0] merged;

  assign full_be  = &be_q;
  assign wr_full  = (state_q == S_ISSUE) && we_q && full_be;
  assign wr_merge = (state_q == S_MERGE);

  // mem_Q still holds the old word here: the memory does not update Q on write cycles.
  mem_be_merge #(.WORD(WORD)) u_merge (
    .old_i    (bus.mem_Q),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_A     = addr_q;

  // Write strobe is combinational so an async reset during MERGE cancels the write at once.
  always_comb begin
    bus.mem_W = 1'b0;
    bus.mem_D = '0;
    if (wr_full) begin
      bus.mem_W = 1'b1;
      bus.mem_D = wdata_q;
    end else if (wr_merge) begin
      bus.mem_W = 1'b1;
      bus.mem_D = merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            we_q    <= bus.req_we;
            if (bus.req_we && (bus.req_be == '0)) begin
`ifdef MEM_REQ_WRITE_ACK_EN
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
`else
              state_q     <= S_IDLE;
`endif
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!we_q) begin
            state_q <= S_WAIT;
          end else if (full_be) begin
`ifdef MEM_REQ_WRITE_ACK_EN
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= S_RESP;
`else
            state_q     <= S_IDLE;
`endif
          end else begin
            state_q <= S_MERGE;
          end
        end
        S_WAIT: begin
          rsp_rdata_q <= bus.mem_Q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_MERGE: begin
`ifdef MEM_REQ_WRITE_ACK_EN
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          state_q     <= S_RESP;
`else
          state_q     <= S_IDLE;
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: behavioural memory, response scoreboard, latency and reset checks.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_req_ctrl_if #(.WORD(32), .ADDR(16)) bus ();

  mem_req_ctrl #(.WORD(32), .ADDR(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  // Single-port memory: one-cycle registered read, Q held on write cycles.
  logic [31:0] mem [0:65535];
  logic        ld_en;
  always @(posedge clk) begin
    if (ld_en) begin
      mem[16'h0010] <= 32'hDEADBEEF;
      mem[16'h0030] <= 32'h11111111;
    end else if (bus.mem_W) begin
      mem[bus.mem_A] <= bus.mem_D;
    end else begin
      bus.mem_Q <= mem[bus.mem_A];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got 0x%08h expected no response", bus.rsp_rdata);
      end else begin
        chk("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after acceptance (cycle 1).
  task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic observe(input int n, output int wc, output int wf, output int vf, output int rf);
    wc = 0; wf = -1; vf = -1; rf = -1;
    for (int c = 1; c <= n; c++) begin
      if (bus.mem_W) begin
        wc++;
        if (wf < 0) wf = c;
      end
      if (bus.rsp_valid && vf < 0) vf = c;
      if (bus.req_ready && rf < 0) rf = c;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, wf, vf, rf;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    ld_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 ld_en = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_W", 32'(bus.mem_W), 32'd0);
    chk("rst_mem_A", 32'(bus.mem_A), 32'd0);
    chk("rst_mem_D", bus.mem_D, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Load of preloaded word.
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    observe(6, wc, wf, vf, rf);
    chk("ld_rsp_cycle", 32'(vf), 32'd3);
    chk("ld_no_write", 32'(wc), 32'd0);
    chk("ld_ready_cycle", 32'(rf), 32'd4);

    // Full store then read back.
`ifdef MEM_REQ_WRITE_ACK_EN
    exp_q.push_back(32'h0);
`endif
    issue(1'b1, 16'h0020, 32'h12345678, 4'hF);
    observe(4, wc, wf, vf, rf);
    chk("fst_write_count", 32'(wc), 32'd1);
    chk("fst_write_cycle", 32'(wf), 32'd1);
`ifdef MEM_REQ_WRITE_ACK_EN
    chk("fst_ack_cycle", 32'(vf), 32'd2);
    chk("fst_ready_cycle", 32'(rf), 32'd3);
`else
    chk("fst_ready_cycle", 32'(rf), 32'd2);
`endif
    exp_q.push_back(32'h12345678);
    issue(1'b0, 16'h0020, 32'h0, 4'h0);
    observe(6, wc, wf, vf, rf);
    chk("fst_ld_rsp_cycle", 32'(vf), 32'd3);

    // Reset during MERGE must cancel the write.
    issue(1'b1, 16'h0010, 32'hFFFFFFFF, 4'b0001);
    chk("rmw_issue_is_read", 32'(bus.mem_W), 32'd0);
    tick();
    chk("rmw_merge_writes", 32'(bus.mem_W), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_mem_W", 32'(bus.mem_W), 32'd0);
    chk("mid_rst_mem_A", 32'(bus.mem_A), 32'd0);
    chk("mid_rst_mem_D", bus.mem_D, 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("mid_rst_mem_intact", mem[16'h0010], 32'hDEADBEEF);

    // Partial store merges one byte.
`ifdef MEM_REQ_WRITE_ACK_EN
    exp_q.push_back(32'h0);
`endif
    issue(1'b1, 16'h0010, 32'h0000AB00, 4'b0010);
    observe(5, wc, wf, vf, rf);
    chk("pst_write_count", 32'(wc), 32'd1);
    chk("pst_write_cycle", 32'(wf), 32'd2);
`ifdef MEM_REQ_WRITE_ACK_EN
    chk("pst_ack_cycle", 32'(vf), 32'd3);
    chk("pst_ready_cycle", 32'(rf), 32'd4);
`else
    chk("pst_ready_cycle", 32'(rf), 32'd3);
`endif
    exp_q.push_back(32'hDEADABEF);
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    observe(6, wc, wf, vf, rf);
    chk("pst_ld_rsp_cycle", 32'(vf), 32'd3);

    // Back-pressured response.
    bus.rsp_ready = 1'b0;
    exp_q.push_back(32'h12345678);
    issue(1'b0, 16'h0020, 32'h0, 4'h0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_rdata", bus.rsp_rdata, 32'h12345678);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
    chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);

    // Store with no enabled bytes.
`ifdef MEM_REQ_WRITE_ACK_EN
    exp_q.push_back(32'h0);
`endif
    issue(1'b1, 16'h0030, 32'hCAFEF00D, 4'h0);
    observe(4, wc, wf, vf, rf);
    chk("be0_no_write", 32'(wc), 32'd0);
`ifdef MEM_REQ_WRITE_ACK_EN
    chk("be0_ack_cycle", 32'(vf), 32'd1);
    chk("be0_ready_cycle", 32'(rf), 32'd2);
`else
    chk("be0_ready_cycle", 32'(rf), 32'd1);
    chk("be0_no_rsp", 32'(vf), 32'hFFFFFFFF);
`endif
    exp_q.push_back(32'h11111111);
    issue(1'b0, 16'h0030, 32'h0, 4'h0);
    observe(6, wc, wf, vf, rf);
    chk("be0_ld_rsp_cycle", 32'(vf), 32'd3);

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
